// File: rtl/rv32i_pkg.sv
// Shared types and control-field encodings for the RV32I multicycle control path.
package rv32i_pkg;

  typedef enum logic [2:0] {
    R_TYPE, I_ALU, LOAD, STORE, BRANCH, JAL, ILLEGAL
  } instr_type_t;

  // S_ prefix keeps the state names from colliding with instr_type_t members.
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_FAULT
  } mc_state_t;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_4      = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] IMM_I       = 2'b00;
  localparam logic [1:0] IMM_S       = 2'b01;
  localparam logic [1:0] IMM_B       = 2'b10;
  localparam logic [1:0] IMM_J       = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] op;
    logic       fault;
  } mc_ctrl_t;

endpackage

// File: rtl/mc_out_dec.sv
// Combinational state-to-control decode for the multicycle sequencer.
module mc_out_dec
  import rv32i_pkg::*;
(
  input  mc_state_t   i_state,
  input  instr_type_t i_instr_type,
  input  logic        i_zero,
  output mc_ctrl_t    o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req    = 1'b1;
        o_ctrl.alu_src_a  = SRCA_PC;
        o_ctrl.alu_src_b  = SRCB_4;
        o_ctrl.op         = ALUOP_ADD;
        o_ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        // Branch target is computed here while the register file is read.
        o_ctrl.alu_src_a = SRCA_OLDPC;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.imm_src   = IMM_B;
        o_ctrl.op        = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = SRCA_RS1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.op        = ALUOP_ADD;
        o_ctrl.imm_src   = (i_instr_type == STORE) ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.result_src = RES_MEM;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.mem_we  = 1'b1;
        o_ctrl.adr_src = 1'b1;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = SRCA_RS1;
        o_ctrl.alu_src_b = SRCB_RS2;
        o_ctrl.op        = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = SRCA_RS1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.imm_src   = IMM_I;
        o_ctrl.op        = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a  = SRCA_RS1;
        o_ctrl.alu_src_b  = SRCB_RS2;
        o_ctrl.op         = ALUOP_SUB;
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.pc_en      = i_zero;
      end
      S_JAL: begin
        // ALU forms old-PC + 4 for the link write in ALUWB.
        o_ctrl.alu_src_a  = SRCA_OLDPC;
        o_ctrl.alu_src_b  = SRCB_4;
        o_ctrl.op         = ALUOP_ADD;
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.pc_en      = 1'b1;
      end
      S_FAULT: o_ctrl.fault = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control sequencer with memory timeout and sticky fault.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl_fsm
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic        clk,
  input  logic        arst,
  input  instr_type_t instr_type,
  input  logic        zero,
  input  logic        halt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_en,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic [1:0]  op,
`ifdef MC_CTRL_PERF_EN
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
`endif
  output logic        fault
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mc_ctrl_fsm: TIMEOUT_CYCLES must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mc_ctrl_fsm: CNT_W must be at least 1");
  end

  mc_state_t     r_state;
  mc_state_t     w_next;
  logic          r_req_out;
  logic [TW-1:0] r_tcnt;
  mc_ctrl_t      w_dec;
  mc_ctrl_t      w_out;
  logic          w_fetch;
  logic          w_req;
  logic          w_wait;
  logic          w_tmo;

  mc_out_dec u_dec (
    .i_state      (r_state),
    .i_instr_type (instr_type),
    .i_zero       (zero),
    .o_ctrl       (w_dec)
  );

  // halt only suppresses a fetch that has not yet been presented to memory.
  assign w_fetch = (r_state == S_FETCH);
  assign w_req   = w_dec.mem_req & ~(w_fetch & halt & ~r_req_out);
  assign w_wait  = w_req & ~mem_ready;
  assign w_tmo   = w_wait & (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_req && mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (instr_type)
          LOAD, STORE: w_next = S_MEMADR;
          R_TYPE:      w_next = S_EXEC_R;
          I_ALU:       w_next = S_EXEC_I;
          BRANCH:      w_next = S_BEQ;
          JAL:         w_next = S_JAL;
          default:     w_next = S_FAULT;
        endcase
      end
      S_MEMADR: w_next = (instr_type == STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC_R: w_next = S_ALUWB;
      S_EXEC_I: w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BEQ:    w_next = S_FETCH;
      S_JAL:    w_next = S_ALUWB;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
    if (w_tmo) w_next = S_FAULT;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= S_FETCH;
      r_req_out <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_state   <= w_next;
      r_req_out <= w_fetch & w_wait & ~w_tmo;
      r_tcnt    <= (w_wait && !w_tmo) ? r_tcnt + TW'(1) : '0;
    end
  end

  // Reset overrides combinationally so an in-flight request drops at once.
  always_comb begin
    w_out          = w_dec;
    w_out.mem_req  = w_req;
    w_out.ir_write = w_fetch & w_req & mem_ready;
    w_out.pc_en    = w_dec.pc_en | (w_fetch & w_req & mem_ready);
    if (arst) begin
      w_out           = '0;
      w_out.alu_src_b = SRCB_4;
    end
  end

  assign mem_req    = w_out.mem_req;
  assign mem_we     = w_out.mem_we;
  assign adr_src    = w_out.adr_src;
  assign ir_write   = w_out.ir_write;
  assign pc_en      = w_out.pc_en;
  assign reg_write  = w_out.reg_write;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign result_src = w_out.result_src;
  assign imm_src    = w_out.imm_src;
  assign op         = w_out.op;
  assign fault      = w_out.fault;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic             w_retire;

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                     (r_state == S_ALUWB) || (r_state == S_BEQ));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (r_state != S_FAULT) r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      if (w_retire)           r_ret_cnt <= r_ret_cnt + CNT_W'(1);
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction reference model builds a cycle
// schedule of inputs and expected controls; a monitor pops and compares each cycle.
module tb_mc_ctrl_fsm;
  import rv32i_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  instr_type_t instr_type = R_TYPE;
  logic        zero = 1'b0;
  logic        halt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, adr_src, ir_write, pc_en, reg_write, fault;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src, op;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
    .clk(clk), .arst(arst), .instr_type(instr_type), .zero(zero), .halt(halt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .op(op),
`ifdef MC_CTRL_PERF_EN
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hlt;
    logic        rdy;
    instr_type_t t;
    logic        z;
    logic [16:0] e;
    logic [31:0] cyc;
    logic [31:0] ret;
  } ent_t;

  ent_t        sched[$];
  ent_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] g_cyc = 0;
  logic [31:0] g_ret = 0;

  // {req,we,adr,irw,pc,rw,a,b,rs,imm,op,fault}
  function automatic logic [16:0] ev(logic req, logic we, logic adr, logic irw, logic pc,
                                     logic rw, logic [1:0] a, logic [1:0] b, logic [1:0] rs,
                                     logic [1:0] imm, logic [1:0] o, logic f);
    return {req, we, adr, irw, pc, rw, a, b, rs, imm, o, f};
  endfunction

  task automatic push(input logic rst, input logic hlt, input logic rdy, input instr_type_t t,
                      input logic z, input logic [16:0] e, input logic retire);
    ent_t x;
    x.rst = rst; x.hlt = hlt; x.rdy = rdy; x.t = t; x.z = z; x.e = e;
    if (rst) begin
      g_cyc = 0; g_ret = 0; x.cyc = 0; x.ret = 0;
    end else begin
      x.cyc = g_cyc; x.ret = g_ret;
      if (!e[0]) g_cyc = g_cyc + 1;
      if (retire) g_ret = g_ret + 1;
    end
    sched.push_back(x);
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    push(1'b1, 1'b0, 1'b0, R_TYPE, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,2'b00,0), 1'b0);
  endtask

  task automatic do_fault(input instr_type_t t);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, t, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,1), 1'b0);
    do_reset();
  endtask

  // Memory phase: request held until ready; TMO waiting cycles without ready means fault.
  task automatic mem_phase(input instr_type_t t, input logic we, input int w, output bit faulted);
    faulted = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      push(1'b0, 1'b0, (i == w), t, 1'b0, ev(1,we,1,0,0,0,0,0,0,0,0,0), we && (i == w));
      if (i == w) begin
        faulted = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_instr(input instr_type_t t, input logic z, input int wf, input int wm,
                           input int halt_pre, input bit halt_mid);
    bit flt;
    for (int i = 0; i < halt_pre; i++)
      push(1'b0, 1'b1, 1'b0, t, z, ev(0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,2'b00,0), 1'b0);
    for (int i = 0; i < wf; i++)
      push(1'b0, halt_mid && (i > 0), 1'b0, t, z, ev(1,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,2'b00,0), 1'b0);
    push(1'b0, halt_mid && (wf > 0), 1'b1, t, z, ev(1,0,0,1,1,0,2'b00,2'b10,2'b10,2'b00,2'b00,0), 1'b0);
    push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b10,2'b00,0), 1'b0);
    case (t)
      R_TYPE, I_ALU: begin
        if (t == R_TYPE) push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b00,2'b10,0), 1'b0);
        else             push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,2'b10,0), 1'b0);
        push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,1,0,0,2'b00,0,0,0), 1'b1);
      end
      LOAD: begin
        push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,2'b00,0), 1'b0);
        mem_phase(t, 1'b0, wm, flt);
        if (flt) do_fault(t);
        else push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,1,0,0,2'b01,0,0,0), 1'b1);
      end
      STORE: begin
        push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b01,2'b00,0), 1'b0);
        mem_phase(t, 1'b1, wm, flt);
        if (flt) do_fault(t);
      end
      BRANCH: push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,z,0,2'b10,2'b00,2'b00,2'b00,2'b01,0), 1'b1);
      JAL: begin
        push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,2'b00,0), 1'b0);
        push(1'b0, 1'b0, 1'b0, t, z, ev(0,0,0,0,0,1,0,0,2'b00,0,0,0), 1'b1);
      end
      default: do_fault(t);
    endcase
  endtask

  initial begin
    instr_type_t legal [6] = '{R_TYPE, I_ALU, LOAD, STORE, BRANCH, JAL};
    int r;
    do_reset();
    run_instr(R_TYPE, 1'b0, 0, 0, 0, 1'b0);
    run_instr(LOAD,   1'b0, 0, 3, 0, 1'b0);
    run_instr(BRANCH, 1'b1, 0, 0, 0, 1'b0);
    run_instr(BRANCH, 1'b0, 0, 0, 0, 1'b0);
    run_instr(JAL,    1'b0, 0, 0, 0, 1'b0);
    run_instr(I_ALU,  1'b0, 2, 0, 0, 1'b1);
    run_instr(STORE,  1'b0, 0, 1, 3, 1'b0);
    run_instr(LOAD,   1'b0, 1, TMO - 1, 0, 1'b0);
    run_instr(STORE,  1'b0, 0, TMO + 4, 0, 1'b0);
    run_instr(ILLEGAL, 1'b0, 0, 0, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 19));
      run_instr((r == 0) ? ILLEGAL : legal[r % 6], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                ($urandom_range(0, 3) == 0));
    end

    #2 arst = 1'b1;
    fork
      begin : driver
        for (int i = 0; i < sched.size(); i++) begin
          @(posedge clk);
          #1;
          arst = sched[i].rst; halt = sched[i].hlt; mem_ready = sched[i].rdy;
          instr_type = sched[i].t; zero = sched[i].z;
        end
      end
      begin : monitor
        ent_t x;
        logic [16:0] act;
        int idx = 0;
        while (exp_q.size() > 0) begin
          @(posedge clk);
          @(negedge clk);
          x = exp_q.pop_front();
          act = {mem_req, mem_we, adr_src, ir_write, pc_en, reg_write,
                 alu_src_a, alu_src_b, result_src, imm_src, op, fault};
          checks++;
          if (act !== x.e) begin
            errors++;
            $display("FAIL ctrl cycle=%0d got=%b want=%b", idx, act, x.e);
          end
`ifdef MC_CTRL_PERF_EN
          checks++;
          if (cyc_cnt !== x.cyc) begin
            errors++;
            $display("FAIL cyc_cnt cycle=%0d got=%0d want=%0d", idx, cyc_cnt, x.cyc);
          end
          checks++;
          if (ret_cnt !== x.ret) begin
            errors++;
            $display("FAIL ret_cnt cycle=%0d got=%0d want=%0d", idx, ret_cnt, x.ret);
          end
`endif
          idx++;
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
